// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] ADD3_VAL    = 4'd3;

  // Segment patterns {g,f,e,d,c,b,a}, index 15 first; codes 10..15 stay dark.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000,
    7'b1101111, 7'b1111111, 7'b0000111, 7'b1111101, 7'b1101101,
    7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
  };

endpackage

// File: rtl/seg7_dec.sv
// One BCD digit to active-high seven-segment pattern {g,f,e,d,c,b,a}.
module seg7_dec
  import bin2bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[digit_i];

endmodule

// File: rtl/bin2bcd_seq.sv
// Double-dabble binary-to-BCD converter, one bit per clock, start/busy/done handshake.
// Define BIN2BCD_SEG_EN to add the seg_o port with per-digit seven-segment decode.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned W      = 10,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [W-1:0]          bin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o
`ifdef BIN2BCD_SEG_EN
  ,
  output logic [7*DIGITS-1:0]   seg_o
`endif
);

  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [W-1:0]          shift_q, shift_d;
  logic [4*DIGITS-1:0]   scr_q, scr_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [4*DIGITS-1:0]   adj;
  logic [4*DIGITS-1:0]   scr_next;

  always_comb begin
    adj = scr_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (scr_q[4*k +: 4] >= ADD3_THRESH) begin
        adj[4*k +: 4] = scr_q[4*k +: 4] + ADD3_VAL;
      end
    end
    scr_next = {adj[4*DIGITS-2:0], shift_q[W-1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          shift_d = bin_i;
          scr_d   = '0;
          cnt_d   = '0;
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        scr_d   = scr_next;
        shift_d = {shift_q[W-2:0], 1'b0};
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          bcd_d   = scr_next;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy_o = (state_q == StShift);
  assign done_o = (state_q == StDone);
  assign bcd_o  = bcd_q;

`ifdef BIN2BCD_SEG_EN
  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_seg
    seg7_dec u_seg7_dec (
      .digit_i (bcd_q[4*g +: 4]),
      .seg_o   (seg_o[7*g +: 7])
    );
  end
`endif

endmodule
